pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 29 ++
 rtl/pipe_adder_if.sv | 35 +++
 rtl/pipe_adder_add_seg.sv | 40 ++++
 rtl/pipe_adder.sv | 138 +++++++++++++
 tb/tb_pipe_adder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder_pkg
// Brief    : Shared defaults and saturation-value helpers for pipe_adder.
// Revision : 1.0
// ============================================================================
package pipe_adder_pkg;

  localparam int unsigned c_def_width = 16;
  localparam int unsigned c_def_seg_w = 4;
  // Helpers return a fixed-width container; callers size-cast to WIDTH.
  localparam int unsigned c_max_width = 64;

  typedef logic [c_max_width-1:0] sat_val_t;

  function automatic sat_val_t sat_max_unsigned(input int unsigned w);
    return (w >= c_max_width) ? '1 : ((sat_val_t'(1) << w) - sat_val_t'(1));
  endfunction

  function automatic sat_val_t sat_max_signed(input int unsigned w);
    return (sat_val_t'(1) << (w - 1)) - sat_val_t'(1);
  endfunction

  function automatic sat_val_t sat_min_signed(input int unsigned w);
    return sat_val_t'(1) << (w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder_if
// Brief    : Operand/result handshake bundle for pipe_adder.
// Revision : 1.0
// ============================================================================
interface pipe_adder_if import pipe_adder_pkg::*; #(
  parameter int WIDTH = c_def_width
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             is_signed;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, is_signed, sat, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, is_signed, sat, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface
`default_nettype wire

// File: rtl/pipe_adder_add_seg.sv
`default_nettype none
// ============================================================================
// Module   : add_seg
// Brief    : One SEG_W-bit adder slice with registered sum and carry.
// Revision : 1.0
// ============================================================================
module add_seg import pipe_adder_pkg::*; #(
  parameter int SEG_W = c_def_seg_w
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_advance,
  input  logic [SEG_W-1:0] i_seg_a,
  input  logic [SEG_W-1:0] i_seg_b,
  input  logic             i_carry,
  output logic [SEG_W-1:0] o_seg_sum,
  output logic             o_carry
);

  logic [SEG_W:0]   w_total;
  logic [SEG_W-1:0] r_seg_sum;
  logic             r_carry;

  assign w_total = {1'b0, i_seg_a} + {1'b0, i_seg_b} + {{SEG_W{1'b0}}, i_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_sum <= '0;
      r_carry   <= 1'b0;
    end else if (i_advance) begin
      r_seg_sum <= w_total[SEG_W-1:0];
      r_carry   <= w_total[SEG_W];
    end
  end

  assign o_seg_sum = r_seg_sum;
  assign o_carry   = r_carry;

endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder
// Brief    : Segmented pipelined adder with wrap/saturate, signed/unsigned.
// Revision : 1.0
// ============================================================================
module pipe_adder import pipe_adder_pkg::*; #(
  parameter int WIDTH = c_def_width,
  parameter int SEG_W = c_def_seg_w
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_adder_if.slave bus
);

  localparam int c_nseg = WIDTH / SEG_W;
  localparam int c_last = c_nseg - 1;

  localparam logic [WIDTH-1:0] c_max_u = WIDTH'(sat_max_unsigned(WIDTH));
  localparam logic [WIDTH-1:0] c_max_s = WIDTH'(sat_max_signed(WIDTH));
  localparam logic [WIDTH-1:0] c_min_s = WIDTH'(sat_min_signed(WIDTH));

  if ((SEG_W < 1) || (SEG_W > WIDTH) || ((WIDTH % SEG_W) != 0) ||
      (WIDTH > int'(c_max_width))) begin : g_bad_params
    $error("pipe_adder: WIDTH must be a multiple of SEG_W with 1 <= SEG_W <= WIDTH <= 64");
  end

  // Per-stage beat payload: operands and mode travel whole with the beat,
  // r_low carries the sum segments already resolved by earlier stages.
  logic             r_vld [c_nseg];
  logic [WIDTH-1:0] r_a   [c_nseg];
  logic [WIDTH-1:0] r_b   [c_nseg];
  logic [WIDTH-1:0] r_low [c_nseg];
  logic             r_sgn [c_nseg];
  logic             r_sat [c_nseg];

  logic [SEG_W-1:0] w_op_a  [c_nseg];
  logic [SEG_W-1:0] w_op_b  [c_nseg];
  logic [SEG_W-1:0] w_seg   [c_nseg];
  logic             w_cin   [c_nseg];
  logic             w_carry [c_nseg];
  logic [WIDTH-1:0] w_res   [c_nseg];

  logic             w_advance;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_a_msb;
  logic             w_b_msb;

  assign w_advance = !r_vld[c_last] || bus.out_ready;

  for (genvar k = 0; k < c_nseg; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_op_a[k] = bus.a[0 +: SEG_W];
      assign w_op_b[k] = bus.b[0 +: SEG_W];
      assign w_cin[k]  = bus.cin;
    end else begin : g_body
      assign w_op_a[k] = r_a[k-1][k*SEG_W +: SEG_W];
      assign w_op_b[k] = r_b[k-1][k*SEG_W +: SEG_W];
      assign w_cin[k]  = w_carry[k-1];
    end

    add_seg #(.SEG_W(SEG_W)) u_seg (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_advance (w_advance),
      .i_seg_a   (w_op_a[k]),
      .i_seg_b   (w_op_b[k]),
      .i_carry   (w_cin[k]),
      .o_seg_sum (w_seg[k]),
      .o_carry   (w_carry[k])
    );

    assign w_res[k] = r_low[k] | (WIDTH'(w_seg[k]) << (k * SEG_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < c_nseg; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_low[k] <= '0;
        r_sgn[k] <= 1'b0;
        r_sat[k] <= 1'b0;
      end
    end else if (w_advance) begin
      r_vld[0] <= bus.in_valid;
      r_a[0]   <= bus.a;
      r_b[0]   <= bus.b;
      r_low[0] <= '0;
      r_sgn[0] <= bus.is_signed;
      r_sat[0] <= bus.sat;
      for (int k = 1; k < c_nseg; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_a[k]   <= r_a[k-1];
        r_b[k]   <= r_b[k-1];
        r_low[k] <= w_res[k-1];
        r_sgn[k] <= r_sgn[k-1];
        r_sat[k] <= r_sat[k-1];
      end
    end
  end

  assign w_raw   = w_res[c_last];
  assign w_cout  = w_carry[c_last];
  assign w_a_msb = r_a[c_last][WIDTH-1];
  assign w_b_msb = r_b[c_last][WIDTH-1];

  // Result formatting reads only final-stage registers, so it is stable
  // while the output beat is stalled and zero straight out of reset.
  always_comb begin
    w_ovf = w_cout;
    if (r_sgn[c_last]) begin
      w_ovf = (w_a_msb == w_b_msb) && (w_raw[WIDTH-1] != w_a_msb);
    end
    w_sum = w_raw;
    if (r_sat[c_last] && w_ovf) begin
      if (!r_sgn[c_last]) begin
        w_sum = c_max_u;
      end else if (w_a_msb) begin
        w_sum = c_min_s;
      end else begin
        w_sum = c_max_s;
      end
    end
  end

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_vld[c_last];
  assign bus.sum       = w_sum;
  assign bus.cout      = w_cout;
  assign bus.ovf       = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_adder
// Brief    : Directed and random self-checking bench for pipe_adder (16/4).
// Revision : 1.0
// ============================================================================
module tb_pipe_adder;

  localparam int WIDTH = 16;
  localparam int SEG_W = 4;

  typedef logic [17:0] res_t;  // {sum, cout, ovf}

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(WIDTH)) bus ();

  pipe_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t exp_q[$];
  res_t got_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   stall_prev = 1'b0;
  res_t held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sgn, input logic sat);
    int unsigned u;
    int          sa, sb, s;
    logic [15:0] r;
    logic        ov;
    u  = 32'(a) + 32'(b) + (cin ? 32'd1 : 32'd0);
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = sa + sb + (cin ? 1 : 0);
    ov = sgn ? ((s > 32767) || (s < -32768)) : (u > 32'd65535);
    r  = u[15:0];
    if (sat && ov) r = sgn ? ((s > 0) ? 16'h7FFF : 16'h8000) : 16'hFFFF;
    return {r, u[16], ov};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive(input bit v, input logic [15:0] a, input logic [15:0] b,
                       input bit cin, input bit sgn, input bit sat, input bit rdy);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.is_signed = sgn;
    bus.sat       = sat;
    bus.out_ready = rdy;
  endtask

  // Called at a falling edge with inputs already applied; samples, scores,
  // then steps through one rising edge back to the next falling edge.
  task automatic cycle(output bit acc);
    res_t obs;
    #1;
    obs = {bus.sum, bus.cout, bus.ovf};
    check("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
    if (stall_prev) check("hold", 32'({bus.out_valid, obs}), 32'({1'b1, held}));
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious", 32'(bus.out_valid), 32'd0);
      end else begin
        check("result", 32'(obs), 32'(exp_q.pop_front()));
        got_q.push_back(obs);
      end
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    held       = obs;
    acc        = bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.is_signed, bus.sat));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0 && n < 100) begin
      cycle(acc);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int lat;
    int sent;
    int acc_n;

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'({bus.sum, bus.cout, bus.ovf}), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Single beat: latency and basic sum
    drive(1'b1, 16'h1234, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(acc);
    check("r034_accept", 32'(acc), 32'd1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      cycle(acc);
      lat++;
    end
    check("r034_latency", 32'(lat), 32'd4);
    drain();
    check("r034_result", 32'(got_q[got_q.size()-1]), 32'({16'h1236, 1'b0, 1'b0}));

    // Overflow and saturation corners, back to back
    got_q.delete();
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1); cycle(acc);
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1); cycle(acc);
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1); cycle(acc);
    drive(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b1); cycle(acc);
    drain();
    check("corner_count", 32'(got_q.size()), 32'd4);
    check("u_wrap", 32'(got_q[0]), 32'({16'h0000, 1'b1, 1'b1}));
    check("u_sat",  32'(got_q[1]), 32'({16'hFFFF, 1'b1, 1'b1}));
    check("s_sat_pos", 32'(got_q[2]), 32'({16'h7FFF, 1'b0, 1'b1}));
    check("s_sat_neg", 32'(got_q[3]), 32'({16'h8000, 1'b1, 1'b1}));

    // Eight-beat stream with a downstream stall in cycles 6..9
    got_q.delete();
    sent = 0;
    for (int t = 0; t < 60 && (sent < 8 || exp_q.size() > 0); t++) begin
      drive(sent < 8, pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom),
            !(t >= 6 && t <= 9));
      cycle(acc);
      if (acc) sent++;
    end
    check("stream_sent", 32'(sent), 32'd8);
    check("stream_delivered", 32'(got_q.size()), 32'd8);

    // Reset with beats in flight
    got_q.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      cycle(acc);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(acc);
    check("flight_out_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result", 32'({bus.sum, bus.cout, bus.ovf}), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle(acc);
    check("midrst_no_result", 32'(got_q.size()), 32'd0);
    check("midrst_ready_after", 32'(bus.in_ready), 32'd1);

    // Random stream with random backpressure
    got_q.delete();
    acc_n = 0;
    for (int t = 0; t < 60000 && acc_n < 10000; t++) begin
      drive($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom_range(0, 9) < 7);
      cycle(acc);
      if (acc) acc_n++;
    end
    check("rnd_accepted", 32'(acc_n), 32'd10000);
    drain();
    check("rnd_delivered", 32'(got_q.size()), 32'd10000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
